// File: rtl/instruction_fetch_pkg.sv
// Shared parameters, FSM encoding and buffer entry type for the instruction fetch unit.
package instruction_fetch_pkg;

    localparam int unsigned WORD_SIZE     = 32;
    localparam int unsigned MEM_ADDR_SIZE = 16;
    localparam int unsigned FETCH_DEPTH   = 2;
    localparam int unsigned CNT_W         = $clog2(FETCH_DEPTH + 1);
    localparam int unsigned IDX_W         = $clog2(FETCH_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQUEST = 2'd1,
        ST_WAIT    = 2'd2,
        ST_STALL   = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [MEM_ADDR_SIZE-1:0] addr;
        logic [WORD_SIZE-1:0]     word;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Small shift-style FIFO of {addr, word}; entry 0 is always the head, so the
// head outputs come straight from a register.
module fetch_buffer
    import instruction_fetch_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     i_push,
    input  logic [MEM_ADDR_SIZE-1:0] i_push_addr,
    input  logic [WORD_SIZE-1:0]     i_push_word,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [CNT_W-1:0]         o_count,
    output logic [MEM_ADDR_SIZE-1:0] o_head_addr,
    output logic [WORD_SIZE-1:0]     o_head_word
);

    fetch_entry_t         r_entry [FETCH_DEPTH];
    logic [CNT_W-1:0]     r_count;
    logic                 w_pop;
    logic                 w_push;
    logic [IDX_W-1:0]     w_wr_idx;

    // Pops need data; pushes need room unless a pop frees a slot in the same cycle.
    assign w_pop    = i_pop && (r_count != '0);
    assign w_push   = i_push && (w_pop || (r_count < CNT_W'(FETCH_DEPTH)));
    assign w_wr_idx = w_pop ? IDX_W'(r_count - CNT_W'(1)) : IDX_W'(r_count);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
            for (int unsigned i = 0; i < FETCH_DEPTH; i++) r_entry[i] <= '0;
        end else if (i_flush) begin
            r_count <= '0;
            for (int unsigned i = 0; i < FETCH_DEPTH; i++) r_entry[i] <= '0;
        end else begin
            if (w_pop) begin
                for (int unsigned i = 0; i + 1 < FETCH_DEPTH; i++) r_entry[i] <= r_entry[i+1];
                r_entry[FETCH_DEPTH-1] <= '0;
            end
            // Later assignment wins, so a push lands on top of the shifted slot.
            if (w_push) r_entry[w_wr_idx] <= '{addr: i_push_addr, word: i_push_word};
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    assign o_count     = r_count;
    assign o_head_addr = r_entry[0].addr;
    assign o_head_word = r_entry[0].word;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: issues one-cycle-latency reads at pc, buffers returned
// words with their addresses, and steps the program counter once per fetch.
module instruction_fetch
    import instruction_fetch_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [MEM_ADDR_SIZE-1:0] pc,
    input  logic                     flush,
    output logic                     mem_read_enable,
    output logic [MEM_ADDR_SIZE-1:0] mem_addr,
    input  logic [WORD_SIZE-1:0]     mem_read_data,
    output logic                     pc_update_enable,
    output logic [WORD_SIZE-1:0]     pc_update_value,
    output logic [WORD_SIZE-1:0]     instr,
    output logic [MEM_ADDR_SIZE-1:0] instr_addr,
    output logic                     instr_valid,
    input  logic                     instr_ready
);

    fetch_state_t             r_state;
    logic                     r_mem_read_enable;
    logic [MEM_ADDR_SIZE-1:0] r_pending_addr;

    logic [CNT_W-1:0]         w_count;
    logic [CNT_W-1:0]         w_next_count;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_valid;

    assign w_valid      = (w_count != '0);
    assign w_push       = (r_state == ST_WAIT) && !flush;
    assign w_pop        = w_valid && instr_ready && !flush;
    assign w_next_count = w_count + CNT_W'(w_push) - CNT_W'(w_pop);

    fetch_buffer u_fetch_buffer (
        .clock       (clock),
        .reset_n     (reset_n),
        .i_push      (w_push),
        .i_push_addr (r_pending_addr),
        .i_push_word (mem_read_data),
        .i_pop       (w_pop),
        .i_flush     (flush),
        .o_count     (w_count),
        .o_head_addr (instr_addr),
        .o_head_word (instr)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state           <= ST_IDLE;
            r_mem_read_enable <= 1'b0;
            r_pending_addr    <= '0;
        end else if (flush) begin
            r_state           <= ST_REQUEST;
            r_mem_read_enable <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state           <= ST_REQUEST;
                    r_mem_read_enable <= 1'b1;
                end
                ST_REQUEST: begin
                    r_state           <= ST_WAIT;
                    r_mem_read_enable <= 1'b0;
                    r_pending_addr    <= pc;
                end
                ST_WAIT: begin
                    if (w_next_count < CNT_W'(FETCH_DEPTH)) begin
                        r_state           <= ST_REQUEST;
                        r_mem_read_enable <= 1'b1;
                    end else begin
                        r_state           <= ST_STALL;
                        r_mem_read_enable <= 1'b0;
                    end
                end
                ST_STALL: begin
                    if (w_count < CNT_W'(FETCH_DEPTH)) begin
                        r_state           <= ST_REQUEST;
                        r_mem_read_enable <= 1'b1;
                    end
                end
                default: begin
                    r_state           <= ST_IDLE;
                    r_mem_read_enable <= 1'b0;
                end
            endcase
        end
    end

    // The pc steps at the edge that ends WAIT, so the address must follow pc live
    // during REQUEST; it is gated to zero whenever no read is being issued.
    assign mem_read_enable  = r_mem_read_enable;
    assign mem_addr         = r_mem_read_enable ? pc : '0;
    assign pc_update_enable = w_push;
    assign pc_update_value  = WORD_SIZE'(1);
    assign instr_valid      = w_valid;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a behavioural pc register and
// a one-cycle-latency instruction memory.
module tb_instruction_fetch;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] pc = 16'h0;
    logic        flush = 1'b0;
    logic        mem_read_enable;
    logic [15:0] mem_addr;
    logic [31:0] mem_read_data = 32'h0;
    logic        pc_update_enable;
    logic [31:0] pc_update_value;
    logic [31:0] instr;
    logic [15:0] instr_addr;
    logic        instr_valid;
    logic        instr_ready = 1'b0;

    logic        pc_load = 1'b0;
    logic [15:0] pc_load_val = 16'h0;
    int          pulses = 0;
    int          base;
    int          errors = 0;
    int          checks = 0;

    instruction_fetch dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .pc               (pc),
        .flush            (flush),
        .mem_read_enable  (mem_read_enable),
        .mem_addr         (mem_addr),
        .mem_read_data    (mem_read_data),
        .pc_update_enable (pc_update_enable),
        .pc_update_value  (pc_update_value),
        .instr            (instr),
        .instr_addr       (instr_addr),
        .instr_valid      (instr_valid),
        .instr_ready      (instr_ready)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return 32'h11 * (32'(a) + 32'd1);
    endfunction

    // Environment: program counter register and instruction memory.
    always @(posedge clock) begin
        if (pc_load) pc <= pc_load_val;
        else if (pc_update_enable) pc <= pc + pc_update_value[15:0];
        if (mem_read_enable) mem_read_data <= mem_word(mem_addr);
        if (pc_update_enable) pulses <= pulses + 1;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input logic rdy);
        reset_n = 1'b0;
        flush = 1'b0;
        instr_ready = rdy;
        pc_load = 1'b1;
        pc_load_val = 16'h0;
        tick();
        pc_load = 1'b0;
        tick();
        reset_n = 1'b1;
        base = pulses;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        checks++; if (mem_read_enable !== 1'b0) begin errors++; $display("FAIL rst_mre: got %b want 0", mem_read_enable); end
        checks++; if (mem_addr !== 16'h0) begin errors++; $display("FAIL rst_mem_addr: got %h want 0000", mem_addr); end
        checks++; if (pc_update_enable !== 1'b0) begin errors++; $display("FAIL rst_pcue: got %b want 0", pc_update_enable); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
        checks++; if ({instr, instr_addr} !== 48'h0) begin errors++; $display("FAIL rst_instr: got %h/%h want 0/0", instr, instr_addr); end
        checks++; if (pc_update_value !== 32'h1) begin errors++; $display("FAIL pc_step: got %h want 00000001", pc_update_value); end
    endtask

    task automatic test_basic();
        do_reset(1'b1);
        tick();
        checks++; if ({mem_read_enable, mem_addr} !== {1'b1, 16'h0}) begin errors++; $display("FAIL basic_req0: got %b/%h want 1/0000", mem_read_enable, mem_addr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b want 0", instr_valid); end
        tick();
        checks++; if ({mem_read_enable, pc_update_enable} !== 2'b01) begin errors++; $display("FAIL basic_wait: got mre=%b pcue=%b want 0/1", mem_read_enable, pc_update_enable); end
        tick();
        checks++; if ({instr_valid, instr, instr_addr} !== {1'b1, 32'h11, 16'h0}) begin errors++; $display("FAIL basic_instr0: got %b %h@%h want 1 00000011@0000", instr_valid, instr, instr_addr); end
        checks++; if ({mem_read_enable, mem_addr} !== {1'b1, 16'h1}) begin errors++; $display("FAIL basic_req1: got %b/%h want 1/0001", mem_read_enable, mem_addr); end
        tick();
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL basic_popped: got %b want 0", instr_valid); end
        tick();
        checks++; if ({instr_valid, instr, instr_addr} !== {1'b1, 32'h22, 16'h1}) begin errors++; $display("FAIL basic_instr1: got %b %h@%h want 1 00000022@0001", instr_valid, instr, instr_addr); end
        checks++; if (pulses - base !== 2) begin errors++; $display("FAIL basic_pulses: got %0d want 2", pulses - base); end
    endtask

    task automatic test_stall();
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) tick();
        checks++; if ({instr_valid, instr, instr_addr} !== {1'b1, 32'h11, 16'h0}) begin errors++; $display("FAIL stall_head: got %b %h@%h want 1 00000011@0000", instr_valid, instr, instr_addr); end
        for (int i = 0; i < 4; i++) begin
            checks++; if ({mem_read_enable, instr} !== {1'b0, 32'h11}) begin errors++; $display("FAIL stall_hold%0d: got mre=%b instr=%h want 0/00000011", i, mem_read_enable, instr); end
            tick();
        end
        checks++; if (pulses - base !== 2) begin errors++; $display("FAIL stall_pulses: got %0d want 2", pulses - base); end
        instr_ready = 1'b1;
        tick();
        checks++; if ({instr_valid, instr, instr_addr, mem_read_enable} !== {1'b1, 32'h22, 16'h1, 1'b0}) begin errors++; $display("FAIL stall_pop1: got %b %h@%h mre=%b want 1 00000022@0001 0", instr_valid, instr, instr_addr, mem_read_enable); end
        tick();
        checks++; if ({instr_valid, mem_read_enable, mem_addr} !== {1'b0, 1'b1, 16'h2}) begin errors++; $display("FAIL stall_resume: got v=%b mre=%b addr=%h want 0 1 0002", instr_valid, mem_read_enable, mem_addr); end
    endtask

    task automatic test_flush();
        do_reset(1'b0);
        for (int i = 0; i < 4; i++) tick();
        flush = 1'b1;
        pc_load = 1'b1;
        pc_load_val = 16'h40;
        #1;
        checks++; if (pc_update_enable !== 1'b0) begin errors++; $display("FAIL flush_pcue: got %b want 0", pc_update_enable); end
        tick();
        flush = 1'b0;
        pc_load = 1'b0;
        checks++; if ({instr_valid, mem_read_enable, mem_addr} !== {1'b0, 1'b1, 16'h40}) begin errors++; $display("FAIL flush_redirect: got v=%b mre=%b addr=%h want 0 1 0040", instr_valid, mem_read_enable, mem_addr); end
        checks++; if (pulses - base !== 1) begin errors++; $display("FAIL flush_pulses: got %0d want 1", pulses - base); end
        tick();
        tick();
        checks++; if ({instr_valid, instr, instr_addr} !== {1'b1, 32'h451, 16'h40}) begin errors++; $display("FAIL flush_refetch: got %b %h@%h want 1 00000451@0040", instr_valid, instr, instr_addr); end
    endtask

    task automatic test_back_to_back();
        do_reset(1'b0);
        for (int i = 0; i < 4; i++) tick();
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        checks++; if ({instr_valid, instr, instr_addr} !== {1'b1, 32'h22, 16'h1}) begin errors++; $display("FAIL b2b_head: got %b %h@%h want 1 00000022@0001", instr_valid, instr, instr_addr); end
        checks++; if ({mem_read_enable, mem_addr} !== {1'b1, 16'h2}) begin errors++; $display("FAIL b2b_req: got %b/%h want 1/0002", mem_read_enable, mem_addr); end
        tick();
        tick();
        checks++; if ({mem_read_enable, instr} !== {1'b0, 32'h22}) begin errors++; $display("FAIL b2b_full: got mre=%b instr=%h want 0/00000022", mem_read_enable, instr); end
    endtask

    task automatic test_reset_mid_wait();
        do_reset(1'b0);
        for (int i = 0; i < 4; i++) tick();
        reset_n = 1'b0;
        #1;
        checks++; if ({mem_read_enable, mem_addr, pc_update_enable, instr_valid} !== 19'h0) begin errors++; $display("FAIL async_ctl: got mre=%b addr=%h pcue=%b v=%b want all 0", mem_read_enable, mem_addr, pc_update_enable, instr_valid); end
        checks++; if ({instr, instr_addr} !== 48'h0) begin errors++; $display("FAIL async_instr: got %h/%h want 0/0", instr, instr_addr); end
        tick();
        reset_n = 1'b1;
        tick();
        checks++; if ({instr_valid, mem_read_enable, mem_addr} !== {1'b0, 1'b1, 16'h1}) begin errors++; $display("FAIL restart_req: got v=%b mre=%b addr=%h want 0 1 0001", instr_valid, mem_read_enable, mem_addr); end
        tick();
        tick();
        checks++; if ({instr_valid, instr, instr_addr} !== {1'b1, 32'h22, 16'h1}) begin errors++; $display("FAIL restart_instr: got %b %h@%h want 1 00000022@0001", instr_valid, instr, instr_addr); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_flush();
        test_back_to_back();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameters SHALL come from the shared parameters header: WORD_SIZE (instruction/data width), MEM_ADDR_SIZE (address width), FETCH_DEPTH = 2 (buffer entries).
REQ-002 Clocking SHALL be one clock; reset SHALL be asynchronous and active-low.
REQ-003 clock  in  1  sole clock; all state updates on rising edge.
REQ-004 reset_n  in  1  asynchronous active-low reset.
REQ-005 pc  in  MEM_ADDR_SIZE  current program counter value.
REQ-006 flush  in  1  discard buffered and in-flight instructions; PC is being redirected.
REQ-007 mem_read_enable  out  1  instruction memory read strobe.
REQ-008 mem_addr  out  MEM_ADDR_SIZE  read address; equals pc while mem_read_enable=1.
REQ-009 mem_read_data  in  WORD_SIZE  read data, valid exactly one cycle after the strobe.
REQ-010 pc_update_enable  out  1  one-cycle pulse to the program counter's update input.
REQ-011 pc_update_value  out  WORD_SIZE  step for the program counter; constant 1.
REQ-012 instr  out  WORD_SIZE  head-of-buffer instruction.
REQ-013 instr_addr  out  MEM_ADDR_SIZE  fetch address of instr.
REQ-014 instr_valid  out  1  buffer non-empty.
REQ-015 instr_ready  in  1  decode accepts instr; transfer when instr_valid && instr_ready.

Function
REQ-016 FSM states SHALL be IDLE, REQUEST, WAIT, STALL.
REQ-017 IDLE SHALL last one cycle after reset release, then go to REQUEST.
REQ-018 REQUEST: mem_read_enable=1, mem_addr=pc, the address is latched as pending; next state WAIT.
REQ-019 WAIT: mem_read_data and the pending address SHALL be pushed into the buffer, and pc_update_enable pulsed; next state REQUEST if the post-edge count is below FETCH_DEPTH, else STALL.
REQ-020 STALL: no request; move to REQUEST on the first cycle the count is below FETCH_DEPTH.
REQ-021 Steady-state throughput SHALL be one instruction per two cycles; fetch latency from REQUEST to instr_valid SHALL be 2 cycles into an empty buffer.
REQ-022 The buffer SHALL be FIFO-ordered; a push and a pop in the same cycle SHALL leave the count unchanged and preserve order.
REQ-023 A request SHALL be issued only when the count is at most FETCH_DEPTH-1; overflow SHALL be impossible by construction.
REQ-024 A pop SHALL occur only when instr_valid=1; instr_ready while empty SHALL have no effect.
REQ-025 instr/instr_addr SHALL be stable while instr_valid=1 and instr_ready=0.
REQ-026 flush, from any state, SHALL:
  - empty the buffer at the next edge;
  - drop the in-flight word and suppress pc_update_enable;
  - go to REQUEST.
  flush has priority over push, pop and pc_update_enable.
REQ-027 pc_update_value SHALL be 1 (zero-extended); address wrap-around is the program counter's modular behaviour, with no special case here.

Reset
REQ-028 reset_n low SHALL immediately force: state IDLE; count 0; pending address 0; buffer contents 0; instr, instr_addr, instr_valid, mem_read_enable, mem_addr, pc_update_enable all 0.
REQ-029 Reset mid-fetch SHALL discard the in-flight read; the returning mem_read_data SHALL be ignored.

Structure
REQ-030 WORD_SIZE, MEM_ADDR_SIZE, FETCH_DEPTH and the FSM state encodings SHALL live in the shared parameters header.
REQ-031 The FIFO SHALL be a sub-module, fetch_buffer:
  - 2 entries of {addr, word};
  - push/pop/flush;
  - count, head outputs.

Verification
REQ-032 Reset release, pc=0, mem returns 0x11 then 0x22, instr_ready=1 -> mem_addr 0 then 1; instr 0x11 @addr 0 valid 3 cycles after release; one pc_update_enable per fetch.
REQ-033 instr_ready=0 held -> exactly 2 fetches (addr 0, 1), then STALL with mem_read_enable=0 and no further pc_update_enable; raise instr_ready -> pops 0x11 then 0x22 in order, fetching resumes.
REQ-034 flush during WAIT, with pc reloaded to 0x40 -> no push, no pc_update_enable, instr_valid=0 next cycle, next request at mem_addr 0x40.
REQ-035 Count=1 with pop and push in the same cycle -> count stays 1; next instr is the newly fetched word.
REQ-036 reset_n asserted mid-WAIT -> all outputs 0 immediately (asynchronous); after release, fetch restarts from the current pc via IDLE.
